// File: rtl/mem_stage.sv
// MEM pipeline stage: owns the data memory, performs loads/stores with a
// configurable multi-cycle latency, stalls the front of the pipeline while an
// access is in flight, and resolves branches from the EX/MEM fields.
//
// Optional feature: define MEM_ALIGN_CHK_EN to flag word-misaligned accesses
// (AlignErr) and suppress them; otherwise address bits [1:0] are ignored.

module mem_stage #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  WB_IN,
    input  logic [2:0]  MEM_IN,
    input  logic [31:0] BranchPC_IN,
    input  logic        Zero_IN,
    input  logic [31:0] AluResult_IN,
    input  logic [31:0] RD2_IN,
    input  logic [4:0]  WR_IN,
    output logic        PCSrc,
    output logic [31:0] BranchPC_OUT,
    output logic        Stall,
    output logic [1:0]  WB_OUT,
    output logic [31:0] ReadData_OUT,
    output logic [31:0] AluResult_OUT,
    output logic [4:0]  WR_OUT,
    output logic        AlignErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;
    // Counter preload on entering BUSY; unused when MEM_LATENCY == 1.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (MEM_LATENCY > 1) ? CNT_W'(MEM_LATENCY - 2) : '0;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mem [DEPTH];

    logic              req;
    logic              misaligned;
    logic              access;
    logic              stall;
    logic              complete;
    logic              mem_we;
    logic [ADDR_W-1:0] index;
    logic              unused_addr;

    assign req   = MEM_IN[1] | MEM_IN[0];
    // Word index; upper address bits wrap modulo the memory depth.
    assign index = AluResult_IN[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHK_EN
    assign misaligned = ~Rst & req & (AluResult_IN[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Only a well-formed request starts or continues an access.
    assign access = req & ~misaligned;

    // Address bits outside the word index are deliberately ignored.
    assign unused_addr = ^AluResult_IN;

    // Next-state, counter and stall/complete decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        if (Rst) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (access) begin
                        if (MEM_LATENCY == 1) begin
                            complete = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = StBusy;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q != '0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        // Upstream holds EX/MEM stable, so access is still valid here.
                        complete = access;
                        state_d  = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stores commit only at the close of the completing cycle.
    assign mem_we = complete & MEM_IN[0];

    // Data memory write port; contents survive reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[index] <= RD2_IN;
        end
    end

    assign PCSrc         = ~Rst & MEM_IN[2] & Zero_IN;
    assign BranchPC_OUT  = BranchPC_IN;
    assign Stall         = stall;
    // Bubble into MEM/WB while stalled, in reset, or on a suppressed access.
    assign WB_OUT        = (Rst | stall | misaligned) ? 2'b00 : WB_IN;
    assign ReadData_OUT  = (complete & MEM_IN[1]) ? mem[index] : 32'h0;
    assign AluResult_OUT = AluResult_IN;
    assign WR_OUT        = WR_IN;
    assign AlignErr      = misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: two instances (latency 4 and latency 1)
// share one stimulus stream and are compared against an address-keyed
// reference memory per instance.

module tb_mem_stage;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LAT   = 4;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_in;
    logic [2:0]  mem_in;
    logic [31:0] bpc_in;
    logic        zero_in;
    logic [31:0] alu_in;
    logic [31:0] rd2_in;
    logic [4:0]  wr_in;

    logic        a_pcsrc, a_stall, a_aerr;
    logic [31:0] a_bpc, a_rd, a_alu;
    logic [1:0]  a_wb;
    logic [4:0]  a_wr;
    logic        b_pcsrc, b_stall, b_aerr;
    logic [31:0] b_bpc, b_rd, b_alu;
    logic [1:0]  b_wb;
    logic [4:0]  b_wr;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(AW), .MEM_LATENCY(LAT)) u_dut (
        .Clk(clk), .Rst(rst), .WB_IN(wb_in), .MEM_IN(mem_in), .BranchPC_IN(bpc_in),
        .Zero_IN(zero_in), .AluResult_IN(alu_in), .RD2_IN(rd2_in), .WR_IN(wr_in),
        .PCSrc(a_pcsrc), .BranchPC_OUT(a_bpc), .Stall(a_stall), .WB_OUT(a_wb),
        .ReadData_OUT(a_rd), .AluResult_OUT(a_alu), .WR_OUT(a_wr), .AlignErr(a_aerr)
    );

    mem_stage #(.ADDR_W(AW), .MEM_LATENCY(1)) u_dut_l1 (
        .Clk(clk), .Rst(rst), .WB_IN(wb_in), .MEM_IN(mem_in), .BranchPC_IN(bpc_in),
        .Zero_IN(zero_in), .AluResult_IN(alu_in), .RD2_IN(rd2_in), .WR_IN(wr_in),
        .PCSrc(b_pcsrc), .BranchPC_OUT(b_bpc), .Stall(b_stall), .WB_OUT(b_wb),
        .ReadData_OUT(b_rd), .AluResult_OUT(b_alu), .WR_OUT(b_wr), .AlignErr(b_aerr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    task automatic drive(input logic [1:0] wb, input logic [2:0] mi, input logic [31:0] addr,
                         input logic [31:0] data, input logic z, input logic [31:0] bpc);
        wb_in   = wb;
        mem_in  = mi;
        alu_in  = addr;
        rd2_in  = data;
        zero_in = z;
        bpc_in  = bpc;
        wr_in   = 5'($urandom);
    endtask

    // Apply one EX/MEM instruction and hold it until the long-latency instance completes.
    task automatic run_op(input logic [1:0] wb, input logic [2:0] mi, input logic [31:0] addr,
                          input logic [31:0] data, input logic z, input logic [31:0] bpc);
        bit is_req, mis, acc, stl;
        int cycles, w;
        drive(wb, mi, addr, data, z, bpc);
        is_req = mi[1] | mi[0];
        mis    = ALIGN_CHK && is_req && (addr[1:0] != 2'b00);
        acc    = is_req && !mis;
        cycles = acc ? int'(LAT) : 1;
        w      = word_of(addr);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            stl = acc && (c < cycles - 1);
            check_eq("stall", 32'(a_stall), 32'(stl));
            check_eq("wb_out", 32'(a_wb), (stl || mis) ? 32'h0 : 32'(wb));
            check_eq("pcsrc", 32'(a_pcsrc), 32'(mi[2] & z));
            check_eq("bpc_out", a_bpc, bpc);
            check_eq("alu_out", a_alu, addr);
            check_eq("wr_out", 32'(a_wr), 32'(wr_in));
            check_eq("align_err", 32'(a_aerr), 32'(mis));
            if (!stl && acc && mi[1]) begin
                if (mem_a.exists(w)) check_eq("rdata", a_rd, mem_a[w]);
            end else begin
                check_eq("rdata_zero", a_rd, 32'h0);
            end
            check_eq("l1_stall", 32'(b_stall), 32'h0);
            check_eq("l1_wb", 32'(b_wb), mis ? 32'h0 : 32'(wb));
            check_eq("l1_pcsrc", 32'(b_pcsrc), 32'(mi[2] & z));
            if (acc && mi[1]) begin
                if (mem_b.exists(w)) check_eq("l1_rdata", b_rd, mem_b[w]);
            end else begin
                check_eq("l1_rdata_zero", b_rd, 32'h0);
            end
            @(posedge clk);
            #1;
            if (acc && mi[0]) begin
                mem_b[w] = data;
                if (!stl) mem_a[w] = data;
            end
        end
    endtask

    // Hold reset with a read+write request present; nothing may happen.
    task automatic reset_cycles(input int n, input logic [31:0] addr, input logic [31:0] data);
        drive(2'b11, 3'b011, addr, data, 1'b1, 32'h40);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_eq("rst_stall", 32'(a_stall), 32'h0);
            check_eq("rst_wb", 32'(a_wb), 32'h0);
            check_eq("rst_pcsrc", 32'(a_pcsrc), 32'h0);
            check_eq("rst_rdata", a_rd, 32'h0);
            check_eq("rst_aerr", 32'(a_aerr), 32'h0);
            check_eq("rst_l1_stall", 32'(b_stall), 32'h0);
            check_eq("rst_l1_rdata", b_rd, 32'h0);
            check_eq("rst_l1_wb", 32'(b_wb), 32'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // Start an access, then assert reset in the second stalled cycle.
    task automatic abort_op(input logic [2:0] mi, input logic [31:0] addr,
                            input logic [31:0] data);
        int w;
        w = word_of(addr);
        drive(2'b10, mi, addr, data, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("abort_stall_first", 32'(a_stall), 32'h1);
        @(posedge clk);
        #1;
        if (mi[0]) mem_b[w] = data;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_rst_stall", 32'(a_stall), 32'h0);
        check_eq("abort_rst_rdata", a_rd, 32'h0);
        check_eq("abort_rst_wb", 32'(a_wb), 32'h0);
        check_eq("abort_rst_l1_rdata", b_rd, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b01, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("abort_idle_stall", 32'(a_stall), 32'h0);
        check_eq("abort_idle_wb", 32'(a_wb), 32'h1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pool_addr(input int i, input logic [1:0] lo);
        int w;
        logic [31:0] hi;
        w  = (i < 8) ? i : (int'(DEPTH) - 16 + i);
        hi = $urandom & ~32'h3FF;
        return hi | 32'(w << 2) | 32'(lo);
    endfunction

    initial begin
        rst = 1'b1;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset held two cycles with a read+write request.
        reset_cycles(2, 32'h0000_0040, 32'h1234_5678);

        // Give the address pool known contents in both instances.
        for (int i = 0; i < 16; i++) begin
            run_op(2'b01, 3'b001, pool_addr(i, 2'b00), $urandom, 1'b0, 32'h0);
        end

        // Reset over a store to a known word must leave it untouched.
        reset_cycles(2, 32'h0000_000C, 32'hA5A5_0000);
        run_op(2'b11, 3'b010, 32'h0000_000C, 32'h0, 1'b0, 32'h0);

        // Store then load, multi-cycle and single-cycle patterns.
        run_op(2'b01, 3'b001, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        run_op(2'b11, 3'b010, 32'h0000_0010, 32'h0, 1'b0, 32'h0);
        run_op(2'b01, 3'b001, 32'h0000_0004, 32'h0000_0005, 1'b0, 32'h0);
        run_op(2'b11, 3'b010, 32'h0000_0004, 32'h0, 1'b0, 32'h0);

        // Branch resolution.
        run_op(2'b00, 3'b100, 32'h0, 32'h0, 1'b1, 32'h0000_0040);
        run_op(2'b00, 3'b100, 32'h0, 32'h0, 1'b0, 32'h0000_0040);

        // Misaligned store to word 4, then read word 4 back.
        run_op(2'b01, 3'b001, 32'h0000_0013, 32'hCAFE_0013, 1'b0, 32'h0);
        run_op(2'b11, 3'b010, 32'h0000_0010, 32'h0, 1'b0, 32'h0);

        // Aborted load, then aborted store leaves the long-latency memory unchanged.
        abort_op(3'b010, 32'h0000_0008, 32'h0);
        abort_op(3'b001, 32'h0000_0008, 32'h7777_8888);
        run_op(2'b11, 3'b010, 32'h0000_0008, 32'h0, 1'b0, 32'h0);

        // Randomized mix over the address pool, with wrapped upper bits.
        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [2:0] mi;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       mi = 3'b000;
                1:       mi = 3'b010;
                2:       mi = 3'b001;
                default: mi = 3'b100;
            endcase
            run_op(2'($urandom), mi, pool_addr(int'($urandom_range(0, 15)), 2'($urandom)),
                   $urandom, 1'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
